// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and wrap-around arithmetic for the Fibonacci stream blocks
package fib_pkg;

   // Default term width used by the generator and checker.
   localparam int FIB_W = 4;

   // Widest term the shared arithmetic helper supports.
   localparam int FIB_MAX_W = 32;

   typedef enum logic [1:0] {
      SEED0,
      SEED1,
      CHECK,
      HALT
   } fib_chk_state_t;

   // Next term of the sequence: sum of the two previous terms, wrapped to w bits.
   // The carry out of the top bit is dropped, so wrap-around is a legal term.
   function automatic logic [FIB_MAX_W-1:0] fib_next(
      input logic [FIB_MAX_W-1:0] a,
      input logic [FIB_MAX_W-1:0] b,
      input int unsigned          w
   );
      logic [FIB_MAX_W-1:0] mask;
      if (w >= 32'(FIB_MAX_W)) begin
         mask = '1;
      end else begin
         mask = (FIB_MAX_W'(1) << w) - FIB_MAX_W'(1);
      end
      return (a + b) & mask;
   endfunction

endpackage

// File: rtl/fib_predictor.sv
// rtl/fib_predictor.sv - two-term history and registered next-term prediction
module fib_predictor
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] expected
);

   // prev1 is the most recent accepted term, prev0 the one before it.
   logic [WIDTH-1:0] prev0;
   logic [WIDTH-1:0] prev1;
   logic [WIDTH-1:0] prev0_d;
   logic [WIDTH-1:0] prev1_d;
   logic [WIDTH-1:0] expected_d;

   // Select the next history pair; clear wins over shift, shift over load.
   always_comb begin
      prev0_d = prev0;
      prev1_d = prev1;
      if (clear) begin
         prev0_d = '0;
         prev1_d = '0;
      end else if (shift) begin
         prev0_d = prev1;
         prev1_d = in_data;
      end else if (load) begin
         prev1_d = in_data;
      end
   end

   // Prediction is taken from the post-update pair so it is valid the cycle after a beat.
   always_comb begin
      expected_d = WIDTH'(fib_next(FIB_MAX_W'(prev0_d), FIB_MAX_W'(prev1_d), WIDTH));
   end

   // History and prediction registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev0    <= '0;
         prev1    <= '0;
         expected <= '0;
      end else begin
         prev0    <= prev0_d;
         prev1    <= prev1_d;
         expected <= expected_d;
      end
   end

endmodule

// File: rtl/fib_stream_checker.sv
// rtl/fib_stream_checker.sv - Fibonacci term stream checker (optional FIB_STREAM_CHECKER_ERRCNT_EN: mismatch counter and resync)
module fib_stream_checker
   import fib_pkg::*;
#(
   parameter int          WIDTH       = FIB_W,
   parameter int unsigned SEED_A      = 1,
   parameter int unsigned SEED_B      = 1,
   parameter bit          CHECK_SEEDS = 1'b1,
   parameter int          CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             err,
   output logic             err_sticky,
   output logic [WIDTH-1:0] expected,
   output logic [CNT_W-1:0] term_cnt
`ifdef FIB_STREAM_CHECKER_ERRCNT_EN
   ,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   localparam logic [WIDTH-1:0] SEED_A_W = WIDTH'(SEED_A);
   localparam logic [WIDTH-1:0] SEED_B_W = WIDTH'(SEED_B);

   fib_chk_state_t state;
   fib_chk_state_t next_state;

   logic beat;
   logic mismatch;
   logic err_beat;
   logic pred_clear;
   logic pred_load;
   logic pred_shift;

   fib_predictor #(
      .WIDTH (WIDTH)
   ) u_predictor (
      .clk      (clk),
      .reset    (reset),
      .clear    (pred_clear),
      .load     (pred_load),
      .shift    (pred_shift),
      .in_data  (in_data),
      .expected (expected)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SEED0;
      end else begin
         state <= next_state;
      end
   end

   // Next-state: restart overrides everything; a beat advances through the seeds into CHECK.
   always_comb begin
      next_state = state;
      if (restart) begin
         next_state = SEED0;
      end else if (beat) begin
         case (state)
            SEED0:   next_state = mismatch ? HALT : SEED1;
            SEED1:   next_state = mismatch ? HALT : CHECK;
`ifdef FIB_STREAM_CHECKER_ERRCNT_EN
            CHECK:   next_state = CHECK;
`else
            CHECK:   next_state = mismatch ? HALT : CHECK;
`endif
            default: next_state = state;
         endcase
      end
   end

   // Per-state compare and predictor control; a restart beat is dropped entirely.
   always_comb begin
      beat       = in_valid && in_ready;
      mismatch   = 1'b0;
      pred_clear = restart;
      pred_load  = 1'b0;
      pred_shift = 1'b0;
      case (state)
         SEED0: begin
            mismatch  = CHECK_SEEDS && (in_data != SEED_A_W);
            pred_load = beat && !mismatch && !restart;
         end
         SEED1: begin
            mismatch   = CHECK_SEEDS && (in_data != SEED_B_W);
            pred_shift = beat && !mismatch && !restart;
         end
         CHECK: begin
            mismatch = (in_data != expected);
`ifdef FIB_STREAM_CHECKER_ERRCNT_EN
            // Resync on a bad term so one glitch does not cascade into a run of errors.
            pred_shift = beat && !restart;
`else
            pred_shift = beat && !mismatch && !restart;
`endif
         end
         default: begin
            mismatch = 1'b0;
         end
      endcase
      err_beat = beat && mismatch && !restart;
   end

   // Handshake, error flags and term counter; restart clears them like reset does.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready   <= 1'b1;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         term_cnt   <= '0;
      end else begin
         in_ready <= (next_state != HALT);
         err      <= err_beat;
         if (restart) begin
            err_sticky <= 1'b0;
            term_cnt   <= '0;
         end else begin
            err_sticky <= err_sticky || err_beat;
            if (beat && (term_cnt != '1)) begin
               term_cnt <= term_cnt + CNT_W'(1);
            end
         end
      end
   end

`ifdef FIB_STREAM_CHECKER_ERRCNT_EN
   // Saturating count of mismatching terms since reset/restart.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (restart) begin
         err_cnt <= '0;
      end else if (err_beat && (err_cnt != '1)) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fib_stream_checker.sv
// tb/tb_fib_stream_checker.sv - scoreboard bench for fib_stream_checker
module tb_fib_stream_checker;

   localparam int W  = 4;
   localparam int CW = 8;
   localparam int MODV = 16;
   localparam int CMAX = 255;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          restart = 1'b0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready;
   logic          err;
   logic          err_sticky;
   logic [W-1:0]  expected;
   logic [CW-1:0] term_cnt;

   logic          b_restart = 1'b0;
   logic          b_valid = 1'b0;
   logic [W-1:0]  b_data = '0;
   logic          b_ready;
   logic          b_err;
   logic          b_err_sticky;
   logic [W-1:0]  b_expected;
   logic [CW-1:0] b_term_cnt;

`ifdef FIB_STREAM_CHECKER_ERRCNT_EN
   logic [CW-1:0] err_cnt;
   logic [CW-1:0] b_err_cnt;
`endif

   fib_stream_checker #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .restart    (restart),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .err        (err),
      .err_sticky (err_sticky),
      .expected   (expected),
      .term_cnt   (term_cnt)
`ifdef FIB_STREAM_CHECKER_ERRCNT_EN
      ,
      .err_cnt    (err_cnt)
`endif
   );

   fib_stream_checker #(.WIDTH(W), .CNT_W(CW), .CHECK_SEEDS(1'b0)) dut_noseed (
      .clk        (clk),
      .reset      (reset),
      .restart    (b_restart),
      .in_valid   (b_valid),
      .in_data    (b_data),
      .in_ready   (b_ready),
      .err        (b_err),
      .err_sticky (b_err_sticky),
      .expected   (b_expected),
      .term_cnt   (b_term_cnt)
`ifdef FIB_STREAM_CHECKER_ERRCNT_EN
      ,
      .err_cnt    (b_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rdy;
      bit e;
      bit es;
      int ex;
      int cnt;
      int ecnt;
   } resp_t;

   resp_t sb[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    seq[$];

   // Reference model: list of accepted good terms summarised by the last two.
   int m_good;
   int m_p0;
   int m_p1;
   int m_cnt;
   int m_ecnt;
   bit m_halt;
   bit m_sticky;

   task automatic check(input string name, input longint act, input longint req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_good = 0; m_p0 = 0; m_p1 = 0; m_cnt = 0; m_ecnt = 0;
      m_halt = 0; m_sticky = 0;
   endtask

   function automatic int model_next_good();
      return (m_good < 2) ? 1 : (m_p0 + m_p1) % MODV;
   endfunction

   task automatic model_step(input bit v, input int d, input bit rs, output resp_t r);
      bit e;
      bit bad;
      e = 0;
      if (rs) begin
         model_reset();
      end else if (v && !m_halt) begin
         if (m_cnt < CMAX) m_cnt++;
         bad = (d != model_next_good());
         if (bad) begin
            e = 1;
            m_sticky = 1;
            if (m_ecnt < CMAX) m_ecnt++;
`ifdef FIB_STREAM_CHECKER_ERRCNT_EN
            if (m_good >= 2) begin
               m_p0 = m_p1;
               m_p1 = d;
            end else begin
               m_halt = 1;
            end
`else
            m_halt = 1;
`endif
         end else begin
            m_p0 = m_p1;
            m_p1 = d;
            m_good++;
         end
      end
      r.rdy  = !m_halt;
      r.e    = e;
      r.es   = m_sticky;
      r.ex   = (m_p0 + m_p1) % MODV;
      r.cnt  = m_cnt;
      r.ecnt = m_ecnt;
   endtask

   task automatic drive(input bit v, input int d, input bit rs);
      resp_t r;
      @(negedge clk);
      in_valid = v;
      in_data  = W'(d);
      restart  = rs;
      model_step(v, d, rs, r);
      sb.push_back(r);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      restart  = 1'b0;
   endtask

   task automatic feed_seq();
      foreach (seq[i]) drive(1'b1, seq[i], 1'b0);
   endtask

   task automatic drive_b(input int d);
      @(negedge clk);
      b_valid = 1'b1;
      b_data  = W'(d);
      @(posedge clk);
      #2;
      b_valid = 1'b0;
   endtask

   // Monitor: one expected response per driven cycle, compared just after the edge.
   always @(posedge clk) begin
      resp_t r;
      #1;
      if (sb.size() > 0) begin
         r = sb.pop_front();
         check("in_ready", in_ready, r.rdy);
         check("err", err, r.e);
         check("err_sticky", err_sticky, r.es);
         check("expected", expected, r.ex);
         check("term_cnt", term_cnt, r.cnt);
`ifdef FIB_STREAM_CHECKER_ERRCNT_EN
         check("err_cnt", err_cnt, r.ecnt);
`endif
      end
   end

   initial begin
      int nd;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_err", err, 0);
      check("rst_err_sticky", err_sticky, 0);
      check("rst_expected", expected, 0);
      check("rst_term_cnt", term_cnt, 0);
      reset = 1'b0;

      // Clean stream with wrap-around (8+13 -> 5).
      seq = '{1, 1, 2, 3, 5, 8, 13, 5, 2, 7};
      feed_seq();
      check("t1_term_cnt", term_cnt, 10);
      check("t1_expected", expected, 9);

      // Bad term halts; the following term is ignored.
      drive(1'b0, 0, 1'b1);
      seq = '{1, 1, 2, 3, 5, 9, 13};
      feed_seq();
`ifndef FIB_STREAM_CHECKER_ERRCNT_EN
      check("t2_in_ready", in_ready, 0);
      check("t2_term_cnt", term_cnt, 6);
`endif
      check("t2_err_sticky", err_sticky, 1);

      // Restart with a same-cycle beat drops the beat.
      drive(1'b1, 1, 1'b1);
      check("t3_term_cnt", term_cnt, 0);
      check("t3_err_sticky", err_sticky, 0);
      seq = '{1, 1, 2};
      feed_seq();

      // Seed mismatch halts even in CHECK-resync builds.
      drive(1'b0, 0, 1'b1);
      drive(1'b1, 2, 1'b0);
      check("t4_in_ready", in_ready, 0);
      drive(1'b1, 1, 1'b0);

      // Unchecked seeds on the second instance.
      drive_b(2); drive_b(3); drive_b(5); drive_b(8);
      check("t4b_err_sticky", b_err_sticky, 0);
      check("t4b_expected", b_expected, 13);
      check("t4b_term_cnt", b_term_cnt, 4);

      // Asynchronous reset between edges clears everything at once.
      drive(1'b0, 0, 1'b1);
      seq = '{1, 1, 2, 4};
      feed_seq();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("t5_err_sticky", err_sticky, 0);
      check("t5_term_cnt", term_cnt, 0);
      check("t5_expected", expected, 0);
      check("t5_in_ready", in_ready, 1);
      check("t5_err", err, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      seq = '{1, 1, 2};
      feed_seq();

`ifdef FIB_STREAM_CHECKER_ERRCNT_EN
      drive(1'b0, 0, 1'b1);
      seq = '{1, 1, 2, 4, 6, 10};
      feed_seq();
      check("t6_err_cnt", err_cnt, 1);
      check("t6_in_ready", in_ready, 1);
`endif

      // Counter saturation on a long clean stream.
      drive(1'b0, 0, 1'b1);
      for (int i = 0; i < 300; i++) drive(1'b1, model_next_good(), 1'b0);
      check("t6_term_cnt_sat", term_cnt, 255);

      // Random traffic: gaps, corrupted terms, occasional restarts.
      drive(1'b0, 0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 15), 1'b1);
         end else begin
            nd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : model_next_good();
            drive($urandom_range(0, 3) != 0, nd, 1'b0);
         end
      end

      repeat (2) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
